rx_capture: RTL and testbench

Receive-side capture controller: the read-path counterpart of the DAC transmit-address sequencer. On a trigger it waits a programmable delay, captures a programmable number of consecutive ADC words, and delivers them as an AXI-Stream packet to the PS-facing `RX_0` stream. It sits in the 215.04 MHz `ref_clk` domain between the RFDC ADC output (`adc_0`) and the `RX_0_tdata`/`RX_0_tvalid`/`RX_0_tready` ports of the block design. A small internal FIFO absorbs downstream back-pressure, and any loss is reported.

---
 rtl/rx_capture.sv | 127 ++++++++++++
 tb/tb_rx_capture.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rx_capture.sv
// rtl/rx_capture.sv - triggered ADC capture into a stream packet through a small FIFO
module rx_capture #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              trig,
    input  logic [CNT_W-1:0]  rxsmps,
    input  logic [CNT_W-1:0]  rxdelay,
    input  logic [DATA_W-1:0] adc_0,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              ovf
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, DELAY, CAPT, DRAIN} state_t;

    state_t               state;
    logic [CNT_W-1:0]     dcnt;
    logic [CNT_W-1:0]     scnt;
    logic [FIFO_AW:0]     wptr;
    logic [FIFO_AW:0]     rptr;
    logic [DATA_W-1:0]    mem_data [DEPTH];
    logic [DEPTH-1:0]     mem_last;
    logic                 ovf_q;

    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 push_last;
    logic                 push_ok;
    logic                 pop;
    logic [FIFO_AW-1:0]   waddr;
    logic [FIFO_AW-1:0]   raddr;
    logic [FIFO_AW-1:0]   paddr;

    // Extra pointer bit distinguishes full from empty; fullness is taken
    // before this cycle's pop so a push into a full FIFO is always dropped.
    assign waddr     = wptr[FIFO_AW-1:0];
    assign raddr     = rptr[FIFO_AW-1:0];
    assign paddr     = waddr - 1'b1;
    assign empty     = (wptr == rptr);
    assign full      = (wptr[FIFO_AW] != rptr[FIFO_AW]) && (waddr == raddr);
    assign push      = (state == CAPT);
    assign push_last = push && (scnt == CNT_W'(1));
    assign push_ok   = push && !full;
    assign pop       = m_tvalid && m_tready;

    // Head entry drives the stream; data is forced to zero while empty so
    // that reset leaves a clean bus even though the storage is not reset.
    assign m_tvalid = !empty;
    assign m_tdata  = empty ? '0 : mem_data[raddr];
    assign m_tlast  = !empty && mem_last[raddr];
    assign busy     = (state != IDLE);
    assign ovf      = ovf_q;

    // Sample storage: written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[waddr] <= adc_0;
        end
    end

    // Control: FSM, delay/sample counters, FIFO pointers, last tags, overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            dcnt     <= '0;
            scnt     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            mem_last <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr            <= wptr + 1'b1;
                mem_last[waddr] <= push_last;
            end else if (push && push_last) begin
                // Final sample lost: terminate the packet on the newest stored beat.
                mem_last[paddr] <= 1'b1;
            end
            if (push && full) begin
                ovf_q <= 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trig && (rxsmps != '0)) begin
                        scnt  <= rxsmps;
                        dcnt  <= rxdelay;
                        ovf_q <= 1'b0;
                        state <= (rxdelay == '0) ? CAPT : DELAY;
                    end
                end
                DELAY: begin
                    dcnt <= dcnt - 1'b1;
                    if (dcnt == CNT_W'(1)) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    scnt <= scnt - 1'b1;
                    if (scnt == CNT_W'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_capture.sv
// tb/tb_rx_capture.sv - directed self-checking bench for rx_capture
module tb_rx_capture;

    logic        clk = 1'b0;
    logic        rstn;
    logic        trig;
    logic [15:0] rxsmps;
    logic [15:0] rxdelay;
    logic [31:0] adc_0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        ovf;

    logic [31:0] adc_cnt = 32'd0;
    logic [31:0] v0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    rx_capture #(.DATA_W(32), .CNT_W(16), .FIFO_AW(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .trig     (trig),
        .rxsmps   (rxsmps),
        .rxdelay  (rxdelay),
        .adc_0    (adc_0),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) adc_cnt <= adc_cnt + 32'd1;
    assign adc_0 = adc_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("check %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; trig is sampled on the following rising edge (T0).
    task automatic fire(input logic [15:0] n, input logic [15:0] d);
        trig    = 1'b1;
        rxsmps  = n;
        rxdelay = d;
        v0      = adc_0;
        @(negedge clk);
        trig    = 1'b0;
    endtask

    task automatic collect(input int n, input logic [31:0] first);
        int idx = 0;
        for (int c = 0; c < 300 && idx < n; c++) begin
            if (m_tvalid && m_tready) begin
                check("beat_data", m_tdata, first + idx);
                check("beat_last", m_tlast, (idx == n - 1));
                idx++;
            end
            @(negedge clk);
        end
        check("beat_count", idx, n);
        check("busy_tail", busy, 1'b1);
        @(negedge clk);
        check("busy_done", busy, 1'b0);
        check("valid_done", m_tvalid, 1'b0);
    endtask

    initial begin
        rstn     = 1'b0;
        trig     = 1'b0;
        rxsmps   = '0;
        rxdelay  = '0;
        m_tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic packet: N=8, D=0, always ready.
        m_tready = 1'b1;
        fire(16'd8, 16'd0);
        check("basic_busy", busy, 1'b1);
        collect(8, v0 + 32'd1);
        check("basic_ovf", ovf, 1'b0);

        // Delay D=5 with a second trigger during DELAY that must be ignored.
        fire(16'd4, 16'd5);
        @(negedge clk);
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        collect(4, v0 + 32'd6);
        repeat (10) @(negedge clk);
        check("delay_no_second", {30'd0, busy, m_tvalid}, 32'd0);

        // Back-pressure filling the FIFO exactly, no loss.
        m_tready = 1'b0;
        fire(16'd16, 16'd0);
        repeat (20) @(negedge clk);
        check("bp_valid", m_tvalid, 1'b1);
        check("bp_ovf", ovf, 1'b0);
        m_tready = 1'b1;
        collect(16, v0 + 32'd1);
        check("bp_ovf_end", ovf, 1'b0);

        // Overflow: 40 samples into 16 entries, last tag moves to 16th beat.
        m_tready = 1'b0;
        fire(16'd40, 16'd0);
        repeat (50) @(negedge clk);
        check("ovf_set", ovf, 1'b1);
        check("ovf_busy", busy, 1'b1);
        m_tready = 1'b1;
        collect(16, v0 + 32'd1);
        check("ovf_sticky", ovf, 1'b1);
        fire(16'd1, 16'd0);
        check("ovf_cleared", ovf, 1'b0);
        collect(1, v0 + 32'd1);

        // Zero-length trigger is ignored.
        fire(16'd0, 16'd3);
        repeat (6) begin
            check("zero_busy", busy, 1'b0);
            check("zero_valid", m_tvalid, 1'b0);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a capture.
        m_tready = 1'b0;
        fire(16'd32, 16'd0);
        repeat (4) @(negedge clk);
        check("pre_rst_valid", m_tvalid, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_valid", m_tvalid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ovf", ovf, 1'b0);
        check("mid_rst_tdata", m_tdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        fire(16'd4, 16'd0);
        collect(4, v0 + 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
